vram_arbiter: RTL
=================

Name: vram_arbiter

Overview:
Sits directly upstream of the video processor's DMA port and in front of the shared 64K video/system SRAM. Arbitrates between the 6800-style CPU and the video DMA engine. On a DMA hold request it halts the CPU via HALT/BA, grants the memory bus to the DMA address/strobe, and returns registered read data to the DMA engine's VDATA input. It then hands the bus back to the CPU.

Parameters:
HANDBACK_CYCLES, 1, cycles cpu_halt stays high with no bus owner after DMA releases hold (range 1..15)
BA_TIMEOUT, 255, max cycles to wait for cpu_ba before flagging bus_err and aborting the request (range 1..255)

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  asynchronous, active-low reset (asserted when 0)
cpu_addr  input  16  CPU address
cpu_wdata  input  8  CPU write data
cpu_rdata  output  8  read data to CPU (combinational from mem_dq_in)
cpu_rw  input  1  1=read, 0=write
cpu_vma  input  1  CPU valid memory address
cpu_ba  input  1  CPU bus-available acknowledge
cpu_halt  output  1  HALT request to CPU
vpu_hold  input  1  DMA bus request
vpu_vramcs  input  1  DMA read strobe
vpu_addr  input  16  DMA address
vpu_data  output  8  registered read data to DMA
mem_addr  output  16  SRAM address
mem_dq_in  input  8  SRAM read data
mem_dq_out  output  8  SRAM write data
mem_ce  output  1  SRAM chip enable
mem_oe  output  1  SRAM output enable
mem_we  output  1  SRAM write enable
grant  output  1  1 while DMA owns the bus
bus_err  output  1  sticky error flag
stats_clr  input  1  clears stolen-cycle counter
stolen_cycles  output  16  stolen-cycle counter

Behaviour:
- Reset (rst=0, async): state=IDLE, cpu_halt=0, grant=0, owner=CPU, vpu_data=0, bus_err=0, stolen_cycles=0.
- Owner mux (combinational from registered owner):
  - CPU owner: mem_addr=cpu_addr, mem_ce=cpu_vma, mem_oe=cpu_vma&cpu_rw, mem_we=cpu_vma&~cpu_rw, mem_dq_out=cpu_wdata.
  - DMA owner: mem_addr=vpu_addr, mem_ce=mem_oe=vpu_vramcs, mem_we=0.
  - NONE owner: ce/oe/we=0, mem_addr=0.
- cpu_rdata=mem_dq_in always.
- vpu_data<=mem_dq_in on every clk while grant&vpu_vramcs; otherwise holds. Latency 1 clk; DMA holds each address ≥2 clk.
- States:
  - IDLE: halt=0, owner=CPU. vpu_hold=1 -> WAIT_BA, halt<=1, timeout counter<=0.
  - WAIT_BA: halt=1, owner=CPU.
    - cpu_ba=1 -> GRANT (owner=DMA, grant=1 next clk).
    - vpu_hold=0 -> IDLE, halt<=0.
    - Counter reaches BA_TIMEOUT -> bus_err<=1, IDLE, halt<=0. Hold stays ignored until vpu_hold returns to 0.
  - GRANT: owner=DMA.
    - vpu_hold=0 -> HANDBACK, owner=NONE, grant<=0, handback counter<=0.
    - cpu_ba falls -> bus_err<=1, owner=NONE, WAIT_BA.
  - HANDBACK: halt=1, owner=NONE.
    - vpu_hold=1 (with cpu_ba=1) -> GRANT directly.
    - Counter==HANDBACK_CYCLES-1 -> IDLE, halt<=0.
- Simultaneous events:
  - vpu_hold rise and cpu_ba already 1 in IDLE: still passes through WAIT_BA (one clk minimum).
  - stats_clr has priority over increment.
- bus_err is cleared only by reset.
- Reset mid-GRANT: bus returns to CPU immediately (async). The DMA engine's own reset is on the same net.

Optional Feature:
VRAM_ARB_STATS_EN
- Defined: stolen_cycles increments each clk with cpu_halt=1, saturating at 16'hFFFF; stats_clr=1 zeroes it on the next clk.
- Undefined: counter logic is absent, stolen_cycles is tied to 0, and stats_clr is ignored.

Test Plan:
- Hold request: vpu_hold=1, cpu_ba asserted 3 clk after cpu_halt -> grant=1 on clk after ba; mem_addr=vpu_addr=16'h4000.
- DMA read: grant, vpu_vramcs=1, mem_dq_in=8'hA5 at vpu_addr 16'h4000 -> vpu_data=8'hA5 one clk later, mem_we=0 throughout.
- Handback with HANDBACK_CYCLES=2: drop vpu_hold -> mem_ce=0 for 2 clk, then cpu_halt=0 and CPU address/strobes on the memory bus.
- No BA with BA_TIMEOUT=8: cpu_ba held 0 -> bus_err=1 and cpu_halt=0 after 8 clk in WAIT_BA; grant never asserts.
- Reset while grant=1: rst=0 mid-cycle -> grant=0, cpu_halt=0, mem_addr=cpu_addr immediately, without a clock edge.
- Stats (VRAM_ARB_STATS_EN): 10-clk halt window -> stolen_cycles=10; stats_clr=1 -> 0 next clk.

Source files
------------

// File: rtl/vram_arbiter.sv
// CPU / video-DMA arbiter for the shared 64K SRAM: halts the CPU via HALT/BA and lends the bus to DMA.
// Optional stolen-cycle counter is built only when VRAM_ARB_STATS_EN is defined.
module vram_arbiter #(
    parameter int HANDBACK_CYCLES = 1,
    parameter int BA_TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    input  logic        cpu_rw,
    input  logic        cpu_vma,
    input  logic        cpu_ba,
    output logic        cpu_halt,
    input  logic        vpu_hold,
    input  logic        vpu_vramcs,
    input  logic [15:0] vpu_addr,
    output logic [7:0]  vpu_data,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_dq_in,
    output logic [7:0]  mem_dq_out,
    output logic        mem_ce,
    output logic        mem_oe,
    output logic        mem_we,
    output logic        grant,
    output logic        bus_err,
    input  logic        stats_clr,
    output logic [15:0] stolen_cycles
);
    typedef enum logic [1:0] {IDLE, WAIT_BA, GRANT, HANDBACK} state_e;
    typedef enum logic [1:0] {OWN_CPU, OWN_DMA, OWN_NONE} owner_e;

    state_e      state_q, state_d;
    owner_e      owner_q, owner_d;
    logic        halt_q, halt_d;
    logic        grant_q, grant_d;
    logic        err_q, err_d;
    logic        block_q, block_d;
    logic [7:0]  ba_cnt_q, ba_cnt_d, ba_cnt_inc;
    logic [3:0]  hb_cnt_q, hb_cnt_d;
    logic [7:0]  vdata_q, vdata_d;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        halt_d     = halt_q;
        grant_d    = grant_q;
        err_d      = err_q;
        // After a BA timeout the stale hold is ignored until DMA drops it once
        block_d    = block_q & vpu_hold;
        ba_cnt_d   = ba_cnt_q;
        hb_cnt_d   = hb_cnt_q;
        ba_cnt_inc = ba_cnt_q + 8'd1;
        case (state_q)
            IDLE: begin
                if (vpu_hold && !block_q) begin
                    state_d  = WAIT_BA;
                    halt_d   = 1'b1;
                    ba_cnt_d = '0;
                end
            end
            WAIT_BA: begin
                if (cpu_ba) begin
                    state_d = GRANT;
                    owner_d = OWN_DMA;
                    grant_d = 1'b1;
                end else if (!vpu_hold) begin
                    state_d = IDLE;
                    owner_d = OWN_CPU;
                    halt_d  = 1'b0;
                end else if (ba_cnt_inc == 8'(BA_TIMEOUT)) begin
                    state_d = IDLE;
                    owner_d = OWN_CPU;
                    halt_d  = 1'b0;
                    err_d   = 1'b1;
                    block_d = 1'b1;
                end else begin
                    ba_cnt_d = ba_cnt_inc;
                end
            end
            GRANT: begin
                if (!vpu_hold) begin
                    state_d  = HANDBACK;
                    owner_d  = OWN_NONE;
                    grant_d  = 1'b0;
                    hb_cnt_d = '0;
                end else if (!cpu_ba) begin
                    // CPU dropped BA under us: float the bus and re-wait for it
                    state_d  = WAIT_BA;
                    owner_d  = OWN_NONE;
                    grant_d  = 1'b0;
                    err_d    = 1'b1;
                    ba_cnt_d = '0;
                end
            end
            HANDBACK: begin
                if (vpu_hold && cpu_ba) begin
                    state_d = GRANT;
                    owner_d = OWN_DMA;
                    grant_d = 1'b1;
                end else if (hb_cnt_q == 4'(HANDBACK_CYCLES - 1)) begin
                    state_d = IDLE;
                    owner_d = OWN_CPU;
                    halt_d  = 1'b0;
                end else begin
                    hb_cnt_d = hb_cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        vdata_d = (grant_q && vpu_vramcs) ? mem_dq_in : vdata_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            owner_q  <= OWN_CPU;
            halt_q   <= 1'b0;
            grant_q  <= 1'b0;
            err_q    <= 1'b0;
            block_q  <= 1'b0;
            ba_cnt_q <= '0;
            hb_cnt_q <= '0;
            vdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            halt_q   <= halt_d;
            grant_q  <= grant_d;
            err_q    <= err_d;
            block_q  <= block_d;
            ba_cnt_q <= ba_cnt_d;
            hb_cnt_q <= hb_cnt_d;
            vdata_q  <= vdata_d;
        end
    end

    always_comb begin
        mem_addr   = '0;
        mem_dq_out = '0;
        mem_ce     = 1'b0;
        mem_oe     = 1'b0;
        mem_we     = 1'b0;
        case (owner_q)
            OWN_CPU: begin
                mem_addr   = cpu_addr;
                mem_dq_out = cpu_wdata;
                mem_ce     = cpu_vma;
                mem_oe     = cpu_vma & cpu_rw;
                mem_we     = cpu_vma & ~cpu_rw;
            end
            OWN_DMA: begin
                mem_addr = vpu_addr;
                mem_ce   = vpu_vramcs;
                mem_oe   = vpu_vramcs;
            end
            default: ;
        endcase
    end

    assign cpu_rdata = mem_dq_in;
    assign cpu_halt  = halt_q;
    assign grant     = grant_q;
    assign bus_err   = err_q;
    assign vpu_data  = vdata_q;

`ifdef VRAM_ARB_STATS_EN
    logic [15:0] stolen_q, stolen_d;

    always_comb begin
        stolen_d = stolen_q;
        if (stats_clr)
            stolen_d = '0;
        else if (halt_q && stolen_q != 16'hFFFF)
            stolen_d = stolen_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stolen_q <= '0;
        else      stolen_q <= stolen_d;
    end

    assign stolen_cycles = stolen_q;
`else
    logic unused_stats_clr;
    assign unused_stats_clr = stats_clr;
    assign stolen_cycles    = '0;
`endif
endmodule
